// File: rtl/memory_data_register.sv
// Memory Data Register: holds one word loaded from data_in, feeds it to data
// memory continuously and to the shared internal bus only when selected.
module memory_data_register #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic             read_bus,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] Bus_out,
    output logic [WIDTH-1:0] DMEM
);

    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] mdr_d;

    always_comb begin
        mdr_d = mdr_q;
        if (write) begin
            mdr_d = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr_q <= '0;
        end else begin
            mdr_q <= mdr_d;
        end
    end

    // Outputs come only from the stored word; no data_in bypass, and the bus
    // is driven low rather than released when not selected.
    assign DMEM    = mdr_q;
    assign Bus_out = read_bus ? mdr_q : '0;

endmodule

// File: tb/tb_memory_data_register.sv
// Scoreboard bench for memory_data_register: expected words are queued as
// stimulus is applied and popped when the outputs are sampled.
module tb_memory_data_register;

    localparam int WIDTH = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             write;
    logic             read_bus;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] Bus_out;
    logic [WIDTH-1:0] DMEM;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] dmem;
        logic [WIDTH-1:0] bus;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model;
    int               checks = 0;
    int               errors = 0;

    memory_data_register #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .write    (write),
        .read_bus (read_bus),
        .data_in  (data_in),
        .Bus_out  (Bus_out),
        .DMEM     (DMEM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_dmem"}, DMEM, e.dmem);
            chk({e.tag, "_bus"}, Bus_out, e.bus);
        end
    endtask

    // Called just after a falling edge; applies inputs, crosses one rising
    // edge, checks, and returns at the next falling edge.
    task automatic cycle(input string tag, input logic w, input logic rb, input logic [WIDTH-1:0] din);
        logic [WIDTH-1:0] nxt;
        write    = w;
        read_bus = rb;
        data_in  = din;
        nxt = (rst_n && w) ? din : model;
        sb.push_back('{tag, nxt, rb ? nxt : '0});
        @(posedge clk);
        model = nxt;
        #1;
        compare_out();
        @(negedge clk);
    endtask

    // Change inputs between edges and check the combinational response.
    task automatic comb(input string tag, input logic w, input logic rb, input logic [WIDTH-1:0] din);
        write    = w;
        read_bus = rb;
        data_in  = din;
        sb.push_back('{tag, model, rb ? model : '0});
        #1;
        compare_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        write    = 1'b1;
        read_bus = 1'b1;
        data_in  = 24'hABCDEF;
        model    = '0;
        @(negedge clk);
        comb("rst_comb", 1'b1, 1'b1, 24'hABCDEF);
        repeat (3) cycle("rst_hold", 1'b1, 1'b1, 24'hABCDEF);

        rst_n = 1'b1;
        cycle("rst_release", 1'b1, 1'b0, 24'hABCDEF);

        cycle("load100", 1'b1, 1'b0, 24'd100);
        comb("bus_read100", 1'b0, 1'b1, 24'd100);
        for (int i = 0; i < 3; i++) begin
            cycle("hold100", 1'b0, 1'b1, 24'($urandom));
        end

        cycle("reload80", 1'b1, 1'b0, 24'd80);
        comb("bus_read80", 1'b0, 1'b1, 24'd80);

        comb("simul_pre", 1'b1, 1'b1, 24'hFFFFFF);
        cycle("simul_post", 1'b1, 1'b1, 24'hFFFFFF);
        cycle("load_zero", 1'b1, 1'b1, 24'h000000);
        cycle("load_ones", 1'b1, 1'b1, 24'hFFFFFF);
        comb("bus_drop", 1'b0, 1'b0, 24'h123456);
        comb("bus_raise", 1'b0, 1'b1, 24'h654321);

        // Pulse reset low between edges: outputs must clear without a clock.
        #2;
        rst_n = 1'b0;
        model = '0;
        comb("arst_mid", 1'b0, 1'b1, 24'h123456);
        #1;
        rst_n = 1'b1;
        cycle("arst_hold", 1'b0, 1'b1, 24'h777777);
        cycle("arst_reload", 1'b1, 1'b1, 24'h555555);

        for (int i = 0; i < 12; i++) begin
            cycle("rand", 1'($urandom), 1'($urandom), 24'($urandom));
        end

        chk("sb_drained", WIDTH'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
